// File: rtl/io_pkg.sv
// Shared constants for io_interface_v2: register offsets, seven-segment lookup
// table and the SD_CTRL reset value.
package io_pkg;

  localparam logic [10:0] SW_OFF      = 11'h000;
  localparam logic [10:0] LED_OFF     = 11'h010;
  localparam logic [10:0] SD_OFF      = 11'h020;
  localparam logic [10:0] SD_CTRL_OFF = 11'h024;
  localparam logic [10:0] PB_OFF      = 11'h030;
  localparam logic [10:0] PB_EDGE_OFF = 11'h034;
  localparam logic [10:0] TIMER_OFF   = 11'h040;

  // All digits blank out of reset so the display stays dark until software sets it up.
  localparam logic [31:0] SD_CTRL_RST = 32'h0000_FF00;

  // Active-low segments, bit0 = a .. bit6 = g, bit7 = dp (off).
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] seg_decode(input logic [3:0] nib,
                                            input logic       dp,
                                            input logic       blank);
    logic [7:0] seg;
    seg = SEG_LUT[nib];
    if (dp)    seg[7] = 1'b0;
    if (blank) seg    = 8'hFF;
    return seg;
  endfunction

endpackage

// File: rtl/pb_debouncer.sv
// Pushbutton debouncer: 2-FF synchronisers, shared sample prescaler and
// two-consecutive-sample acceptance; emits debounced state and a one-cycle rise vector.
module pb_debouncer #(
  parameter int PB_WIDTH        = 20,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PB_WIDTH-1:0] pb_i,
  output logic [PB_WIDTH-1:0] state_o,
  output logic [PB_WIDTH-1:0] rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [PB_WIDTH-1:0] sync1_q, sync2_q;
  logic [PB_WIDTH-1:0] prev_q, prev_d;
  logic [PB_WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tick;

  assign tick = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    prev_d  = prev_q;
    state_d = state_q;
    if (tick) begin
      prev_d  = sync2_q;
      // A bit only moves when this sample agrees with the previous one.
      state_d = (state_q & (sync2_q ^ prev_q)) | (sync2_q & ~(sync2_q ^ prev_q));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pb_i;
      sync2_q <= sync1_q;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = state_d & ~state_q;

endmodule

// File: rtl/io_interface_v2.sv
// Memory-mapped IO block: switches, LEDs, 8-digit seven-segment display and
// debounced pushbuttons with W1C edge capture. Define IO_TIMER_EN for the cycle timer.
module io_interface_v2
  import io_pkg::*;
#(
  parameter int DATAWIDTH       = 32,
  parameter int ADDRWIDTH       = 32,
  parameter int SW_WIDTH        = 32,
  parameter int LED_WIDTH       = 32,
  parameter int PB_WIDTH        = 20,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 iClk,
  input  logic                 iReset_n,
  input  logic [ADDRWIDTH-1:0] iAddress,
  input  logic [DATAWIDTH-1:0] iWriteData,
  output logic [DATAWIDTH-1:0] oReadData,
  input  logic                 iWR,
  input  logic                 iIOS,
  output logic [7:0]           oSSLED7,
  output logic [7:0]           oSSLED6,
  output logic [7:0]           oSSLED5,
  output logic [7:0]           oSSLED4,
  output logic [7:0]           oSSLED3,
  output logic [7:0]           oSSLED2,
  output logic [7:0]           oSSLED1,
  output logic [7:0]           oSSLED0,
  output logic [31:0]          oLED,
  input  logic [19:0]          iPB,
  input  logic [31:0]          iSW
);

  logic [10:0] offset;
  logic        wr_en;
  logic        unused_addr_hi;

  assign offset         = iAddress[10:0];
  assign wr_en          = iIOS & iWR;
  assign unused_addr_hi = ^iAddress[ADDRWIDTH-1:11];

  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [31:0]          sd_data_q, sd_data_d;
  logic [7:0]           dp_q, dp_d;
  logic [7:0]           blank_q, blank_d;
  logic [PB_WIDTH-1:0]  pb_state, pb_rise;
  logic [PB_WIDTH-1:0]  pb_edge_q, pb_edge_d, pb_clr;

  pb_debouncer #(
    .PB_WIDTH        (PB_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pb_debouncer (
    .clk_i   (iClk),
    .rst_ni  (iReset_n),
    .pb_i    (iPB[PB_WIDTH-1:0]),
    .state_o (pb_state),
    .rise_o  (pb_rise)
  );

  always_comb begin
    led_d     = led_q;
    sd_data_d = sd_data_q;
    dp_d      = dp_q;
    blank_d   = blank_q;
    pb_clr    = '0;
    if (wr_en) begin
      case (offset)
        LED_OFF:     led_d     = iWriteData[LED_WIDTH-1:0];
        SD_OFF:      sd_data_d = iWriteData[31:0];
        SD_CTRL_OFF: begin
          dp_d    = iWriteData[7:0];
          blank_d = iWriteData[15:8];
        end
        PB_EDGE_OFF: pb_clr    = iWriteData[PB_WIDTH-1:0];
        default: ;
      endcase
    end
    // A rise landing on the same edge as its clear must not be lost.
    pb_edge_d = (pb_edge_q & ~pb_clr) | pb_rise;
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      led_q     <= '0;
      sd_data_q <= '0;
      dp_q      <= SD_CTRL_RST[7:0];
      blank_q   <= SD_CTRL_RST[15:8];
      pb_edge_q <= '0;
    end else begin
      led_q     <= led_d;
      sd_data_q <= sd_data_d;
      dp_q      <= dp_d;
      blank_q   <= blank_d;
      pb_edge_q <= pb_edge_d;
    end
  end

`ifdef IO_TIMER_EN
  logic [31:0] timer_q, timer_d;

  assign timer_d = (wr_en && offset == TIMER_OFF) ? iWriteData[31:0] : timer_q + 32'd1;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) timer_q <= '0;
    else           timer_q <= timer_d;
  end
`endif

  always_comb begin
    oReadData = '0;
    if (iIOS) begin
      case (offset)
        SW_OFF:      oReadData[SW_WIDTH-1:0]  = iSW[SW_WIDTH-1:0];
        LED_OFF:     oReadData[LED_WIDTH-1:0] = led_q;
        SD_OFF:      oReadData[31:0]          = sd_data_q;
        SD_CTRL_OFF: oReadData[15:0]          = {blank_q, dp_q};
        PB_OFF:      oReadData[PB_WIDTH-1:0]  = pb_state;
        PB_EDGE_OFF: oReadData[PB_WIDTH-1:0]  = pb_edge_q;
`ifdef IO_TIMER_EN
        TIMER_OFF:   oReadData[31:0]          = timer_q;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    oLED                  = '0;
    oLED[LED_WIDTH-1:0]   = led_q;
  end

  logic [7:0] seg [8];

  for (genvar n = 0; n < 8; n++) begin : g_digit
    assign seg[n] = seg_decode(sd_data_q[4*n +: 4], dp_q[n], blank_q[n]);
  end

  assign oSSLED0 = seg[0];
  assign oSSLED1 = seg[1];
  assign oSSLED2 = seg[2];
  assign oSSLED3 = seg[3];
  assign oSSLED4 = seg[4];
  assign oSSLED5 = seg[5];
  assign oSSLED6 = seg[6];
  assign oSSLED7 = seg[7];

endmodule

// File: tb/tb_io_interface_v2.sv
// Scoreboard bench for io_interface_v2 (LED_WIDTH=8, DEBOUNCE_CYCLES=4) with a
// behavioural register/debounce model; follows IO_TIMER_EN like the design.
module tb_io_interface_v2;

  localparam int N_DEB = 4;

  logic        clk, rst_n;
  logic [31:0] addr, wdata, rdata, led_o, sw;
  logic        wr, ios;
  logic [19:0] pb;
  logic [7:0]  seg_o [8];

  io_interface_v2 #(
    .DATAWIDTH(32), .ADDRWIDTH(32), .SW_WIDTH(32), .LED_WIDTH(8),
    .PB_WIDTH(20), .DEBOUNCE_CYCLES(N_DEB)
  ) dut (
    .iClk(clk), .iReset_n(rst_n), .iAddress(addr), .iWriteData(wdata),
    .oReadData(rdata), .iWR(wr), .iIOS(ios),
    .oSSLED7(seg_o[7]), .oSSLED6(seg_o[6]), .oSSLED5(seg_o[5]), .oSSLED4(seg_o[4]),
    .oSSLED3(seg_o[3]), .oSSLED2(seg_o[2]), .oSSLED1(seg_o[1]), .oSSLED0(seg_o[0]),
    .oLED(led_o), .iPB(pb), .iSW(sw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [7:0]  hex7 [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0]  m_led, m_dp, m_blank;
  logic [31:0] m_sd, m_timer;
  logic [19:0] m_s1, m_s2, m_prev, m_state, m_edge, m_clr, m_new;
  int          m_cyc;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_led = '0; m_sd = '0; m_dp = '0; m_blank = 8'hFF; m_timer = '0;
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_state = '0; m_edge = '0; m_cyc = 0;
    end else begin
      m_clr = '0;
`ifdef IO_TIMER_EN
      m_timer = m_timer + 32'd1;
`endif
      if (ios && wr) begin
        case (addr[10:0])
          11'h010: m_led = wdata[7:0];
          11'h020: m_sd  = wdata;
          11'h024: begin m_dp = wdata[7:0]; m_blank = wdata[15:8]; end
          11'h034: m_clr = wdata[19:0];
`ifdef IO_TIMER_EN
          11'h040: m_timer = wdata;
`endif
          default: ;
        endcase
      end
      m_new = m_state;
      if (m_cyc % N_DEB == N_DEB - 1) begin
        for (int b = 0; b < 20; b++)
          if (m_s2[b] == m_prev[b]) m_new[b] = m_s2[b];
        m_prev = m_s2;
      end
      m_edge  = (m_edge & ~m_clr) | (m_new & ~m_state);
      m_state = m_new;
      m_s2    = m_s1;
      m_s1    = pb;
      m_cyc   = m_cyc + 1;
    end
  end

  function automatic logic [31:0] model_read(input logic [10:0] off);
    case (off)
      11'h000: return sw;
      11'h010: return {24'h0, m_led};
      11'h020: return m_sd;
      11'h024: return {16'h0, m_blank, m_dp};
      11'h030: return {12'h0, m_state};
      11'h034: return {12'h0, m_edge};
`ifdef IO_TIMER_EN
      11'h040: return m_timer;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input int n);
    logic [7:0] s;
    s = hex7[m_sd[4*n +: 4]];
    if (m_dp[n])    s[7] = 1'b0;
    if (m_blank[n]) s = 8'hFF;
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } obs_t;

  obs_t        sbq[$];
  obs_t        mon_o;
  logic [31:0] mon_act;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] pick(input int sel);
    if (sel == 0) return rdata;
    if (sel == 1) return led_o;
    return {24'h0, seg_o[sel-2]};
  endfunction

  initial forever begin
    @(negedge clk);
    #2;
    while (sbq.size() > 0) begin
      mon_o   = sbq.pop_front();
      mon_act = pick(mon_o.sel);
      checks++;
      if (mon_act !== mon_o.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", mon_o.name, mon_act, mon_o.exp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_obs(input int sel, input logic [31:0] exp, input string nm);
    obs_t o;
    o.sel = sel; o.exp = exp; o.name = nm;
    sbq.push_back(o);
  endtask

  task automatic set_addr(input logic [10:0] off);
    addr = {21'($urandom), off};
  endtask

  task automatic rd(input logic [10:0] off, input logic io, input logic [31:0] exp, input string nm);
    set_addr(off);
    ios = io; wr = 1'b0;
    expect_obs(0, exp, nm);
    @(negedge clk);
    ios = 1'b0;
  endtask

  task automatic rd_model(input logic [10:0] off, input logic io, input string nm);
    rd(off, io, io ? model_read(off) : 32'h0, nm);
  endtask

  task automatic wr_reg(input logic [10:0] off, input logic [31:0] d);
    set_addr(off);
    wdata = d; ios = 1'b1; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; ios = 1'b0;
  endtask

  task automatic chk_disp(input string nm);
    for (int n = 0; n < 8; n++) expect_obs(2 + n, {24'h0, model_seg(n)}, nm);
    expect_obs(1, {24'h0, m_led}, nm);
    @(negedge clk);
  endtask

  logic [10:0] offs [10] = '{11'h000, 11'h010, 11'h020, 11'h024, 11'h030,
                             11'h034, 11'h040, 11'h044, 11'h7FC, 11'h110};
  logic [10:0] r_off;
  logic [31:0] r_dat;
  bit          hit;

  initial begin
    rst_n = 1'b0; addr = '0; wdata = '0; wr = 1'b0; ios = 1'b0; pb = '0; sw = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    for (int n = 0; n < 8; n++) expect_obs(2 + n, 32'hFF, "rst_seg");
    expect_obs(1, 32'h0, "rst_led");
    @(negedge clk);
    rd(11'h024, 1'b1, 32'h0000_FF00, "rst_sdctrl");
    rd(11'h010, 1'b0, 32'h0, "ios_low_led");

    // LED width masking and switches
    sw = 32'h0000_1234;
    wr_reg(11'h010, 32'hA5A5_A5A5);
    expect_obs(1, 32'h0000_00A5, "led_out");
    rd(11'h010, 1'b1, 32'h0000_00A5, "led_rd");
    rd(11'h000, 1'b1, 32'h0000_1234, "sw_rd");

    // seven-segment decode, dp and blank
    wr_reg(11'h020, 32'h0123_ABCF);
    wr_reg(11'h024, 32'h0000_0001);
    expect_obs(2, 32'h0E, "seg0_dp");
    expect_obs(9, 32'hC0, "seg7_zero");
    @(negedge clk);
    wr_reg(11'h024, 32'h0000_8000);
    expect_obs(9, 32'hFF, "seg7_blank");
    @(negedge clk);
    chk_disp("disp_model");

    // randomised register traffic
    for (int i = 0; i < 60; i++) begin
      sw    = $urandom;
      r_off = offs[$urandom_range(0, 9)];
      r_dat = $urandom;
      if ($urandom_range(0, 1) == 1) wr_reg(r_off, r_dat);
      r_off = offs[$urandom_range(0, 9)];
      rd_model(r_off, $urandom_range(0, 3) != 0, "rand_rd");
      if (i % 6 == 0) chk_disp("rand_disp");
    end

    // glitch shorter than two samples is rejected
    pb[3] = 1'b1;
    repeat (3) @(negedge clk);
    pb[3] = 1'b0;
    repeat (10) @(negedge clk);
    rd(11'h030, 1'b1, 32'h0, "pb_glitch");
    rd_model(11'h034, 1'b1, "pb_glitch_edge");

    // clear anything random traffic may have left, then a clean press
    wr_reg(11'h034, 32'hFFFF_FFFF);
    pb[3] = 1'b1;
    repeat (12) @(negedge clk);
    rd(11'h030, 1'b1, 32'h8, "pb_state_held");
    rd(11'h034, 1'b1, 32'h8, "pb_edge_set");
    wr_reg(11'h034, 32'h8);
    rd(11'h034, 1'b1, 32'h0, "pb_edge_w1c");
    rd_model(11'h030, 1'b1, "pb_state_model");

    // rise of bit 0 on the same edge as a W1C of bit 0
    pb[0] = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      set_addr(11'h034);
      wdata = 32'h1; ios = 1'b1; wr = 1'b1;
      @(negedge clk);
      if (m_state[0]) hit = 1'b1;
    end
    wr = 1'b0; ios = 1'b0;
    if (!hit) begin
      errors++;
      $display("FAIL pb0_rise_timeout: got no rise expected rise within 40 cycles");
    end
    rd(11'h034, 1'b1, 32'h1, "pb_set_wins");
    rd_model(11'h030, 1'b1, "pb_state_both");

    // release: state falls, edge stays latched
    pb = '0;
    repeat (12) @(negedge clk);
    rd(11'h030, 1'b1, 32'h0, "pb_release");
    rd(11'h034, 1'b1, 32'h1, "pb_edge_sticky");

`ifdef IO_TIMER_EN
    wr_reg(11'h040, 32'hFFFF_FFFE);
    rd(11'h040, 1'b1, 32'hFFFF_FFFE, "timer_load");
    rd(11'h040, 1'b1, 32'hFFFF_FFFF, "timer_inc");
    rd(11'h040, 1'b1, 32'h0000_0000, "timer_wrap");
    rd_model(11'h040, 1'b1, "timer_model");
`else
    wr_reg(11'h040, 32'h1234_5678);
    rd(11'h040, 1'b1, 32'h0, "timer_absent");
`endif

    // asynchronous reset mid-operation
    wr_reg(11'h010, 32'h5A);
    wr_reg(11'h024, 32'h0);
    set_addr(11'h040);
    ios = 1'b1;
    expect_obs(0, 32'h0, "rst_mid_timer");
    expect_obs(1, 32'h0, "rst_mid_led");
    expect_obs(2, 32'hFF, "rst_mid_seg0");
    #1 rst_n = 1'b0;
    @(negedge clk);
    ios = 1'b0;
    rst_n = 1'b1;
    rd(11'h034, 1'b1, 32'h0, "rst_mid_edge");
    rd(11'h024, 1'b1, 32'h0000_FF00, "rst_mid_sdctrl");

    repeat (2) @(negedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_interface_v2.md
Name: io_interface_v2

Overview:
Memory-mapped peripheral interface for the RISC-V core's IO space (iIOS region, offsets decoded from iAddress[10:0]). Successor to the basic switch/LED port:
- widths are parametrised;
- adds a hex-decoded eight-digit seven-segment display with blank and decimal-point masks;
- adds debounced pushbuttons with a write-1-to-clear edge-capture register;
- optionally adds a free-running cycle timer.

Sits between the core's load/store path and the board pins.

Parameters:
DATAWIDTH, 32, bus data width (must be 32)
ADDRWIDTH, 32, bus address width; only bits [10:0] decoded
SW_WIDTH, 32, switch inputs used (1..32)
LED_WIDTH, 32, LED register width (1..32)
PB_WIDTH, 20, pushbutton inputs used (1..20)
DEBOUNCE_CYCLES, 500000, clocks between debounce samples (>=2)

Ports:
iClk  in  1  system clock
iReset_n  in  1  asynchronous active-low reset
iAddress  in  ADDRWIDTH  bus address
iWriteData  in  DATAWIDTH  store data
oReadData  out  DATAWIDTH  load data (combinational)
iWR  in  1  write strobe
iIOS  in  1  IO-space select
oSSLED7..oSSLED0  out  8 each  digit segments, active-low, bit0=a..bit6=g, bit7=dp
oLED  out  32  LED outputs; bits above LED_WIDTH tied 0
iPB  in  20  raw pushbuttons, active-high, asynchronous
iSW  in  32  switches (read directly, no synchroniser)

Behaviour:
- Clock and reset: one clock iClk; reset is asynchronous and active-low (iReset_n).
- Register map (11-bit offsets):
  - 0x000 SW: read only.
  - 0x010 LED: R/W.
  - 0x020 SD_DATA: R/W, 8 hex nibbles; digit n = bits [4n+3:4n].
  - 0x024 SD_CTRL: R/W; [7:0] dp mask (1 = dp lit); [15:8] blank mask (1 = digit dark); other bits read 0.
  - 0x030 PB_STATE: read only, debounced.
  - 0x034 PB_EDGE: read; write-1-to-clear.
  - 0x040 TIMER: optional feature only.
- Write: on iClk rising edge when iIOS & iWR & offset match; full word written, masked to the field width. Writes to read-only or unmapped offsets are ignored.
- Read: combinational. Zero-extended field when iIOS & offset match; otherwise all zeros, including when iIOS is low and on unmapped offsets.
- Reset values:
  - LED = 0, SD_DATA = 0.
  - SD_CTRL = 0x0000_FF00 (all digits blank, so every oSSLED = 0xFF).
  - PB synchronisers, PB_STATE, PB_EDGE, previous-sample regs, prescaler = 0.
- Seven-segment decode, combinational from registers, so outputs change the cycle after the write edge:
  - 0..F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
  - dp mask bit set clears bit7.
  - blank bit set forces 0xFF and overrides dp.
- Debounce (all PB bits):
  - 2-FF synchroniser per bit.
  - Shared prescaler counts 0..DEBOUNCE_CYCLES-1 and pulses tick on the terminal count, then wraps to 0.
  - On tick, each synced bit is sampled. PB_STATE bit takes the sample only if it equals that bit's previous sample; the previous sample is then updated.
  - Net result: a level must be stable for two consecutive ticks to be accepted.
- Edge capture:
  - A 0->1 transition of a PB_STATE bit sets the PB_EDGE bit in the same cycle PB_STATE updates.
  - A W1C write clears the bits written as 1.
  - Set and clear of the same bit in the same cycle: set wins.
  - Bits remain set until cleared; no counting.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); the prescaler restarts from 0.

Optional Feature:
IO_TIMER_EN
- Defined: a 32-bit TIMER at offset 0x040.
  - Increments every clock and wraps 0xFFFF_FFFF -> 0.
  - A write loads iWriteData; the write takes priority over the increment, and the next cycle continues from the loaded value + 1.
  - Reset value 0.
- Not defined: no counter is instantiated; 0x040 reads 0 and writes are ignored.

Decomposition:
- Package io_pkg:
  - offset constants SW_OFF, LED_OFF, SD_OFF, SD_CTRL_OFF, PB_OFF, PB_EDGE_OFF, TIMER_OFF;
  - 16-entry seven-segment lookup constant;
  - SD_CTRL reset constant.
- One sub-module, pb_debouncer, parametrised by PB_WIDTH and DEBOUNCE_CYCLES. It contains the synchronisers, prescaler, sample logic and PB_STATE, and outputs state plus a one-cycle rise vector. Edge capture and the bus logic stay in the top module.

Test Plan:
- Release reset -> all oSSLED = 0xFF, oLED = 0; read 0x024 = 0x0000FF00; read with iIOS=0 at 0x010 = 0.
- Write LED 0xA5A5A5A5 with LED_WIDTH=8 -> oLED = 0x000000A5, read 0x010 = 0xA5; iSW=0x1234 -> read 0x000 = 0x1234.
- Write SD_DATA 0x0123ABCF, SD_CTRL 0x0000_0001 -> oSSLED0 = 0x0E, oSSLED7 = 0xC0; then SD_CTRL 0x8000 -> oSSLED7 = 0xFF.
- DEBOUNCE_CYCLES=4, iPB[3] glitch of 3 clocks -> PB_STATE stays 0. Hold iPB[3] for 12 clocks -> PB_STATE = 0x8 and PB_EDGE = 0x8. Write 0x8 to 0x034 -> PB_EDGE = 0.
- Rise on iPB[0] aligned so set coincides with a W1C of bit 0 -> PB_EDGE[0] = 1.
- IO_TIMER_EN defined: write 0xFFFFFFFE to 0x040 -> reads FFFFFFFF, then 0 on successive cycles. Reset pulse mid-count -> 0. Macro undefined: read 0x040 = 0.
